// File: rtl/present_dec.sv
// PRESENT-80 iterative block decryptor: key expansion, one inverse round per cycle, final whitening.
// Optional PRESENT_DEC_KEY_REUSE_EN caches the last expanded key so a repeated key skips KEYEXP.
module present_dec #(
  parameter int ROUNDS = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] ciphertext,
  input  logic [79:0] key_in,
  output logic [63:0] plaintext,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] ROUNDS_L = 5'(ROUNDS);

  typedef enum logic [1:0] {IDLE, KEYEXP, DEC, FINAL} fsm_e;

  fsm_e        fsm_q;
  logic [63:0] state_q;
  logic [79:0] key_q;
  logic [4:0]  r_q;
  logic [63:0] plaintext_q;
  logic        busy_q;
  logic        done_q;

  logic [79:0] key_fwd_d;
  logic [79:0] key_inv_d;
  logic [63:0] state_dec_d;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
      4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
      4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
      4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
    endcase
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'h5;  4'h1: return 4'hE;  4'h2: return 4'hF;  4'h3: return 4'h8;
      4'h4: return 4'hC;  4'h5: return 4'h1;  4'h6: return 4'h2;  4'h7: return 4'hD;
      4'h8: return 4'hB;  4'h9: return 4'h4;  4'hA: return 4'h6;  4'hB: return 4'h3;
      4'hC: return 4'h0;  4'hD: return 4'h7;  4'hE: return 4'h9;  default: return 4'hA;
    endcase
  endfunction

  function automatic logic [63:0] inv_s_layer(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 16; i++) y[4*i +: 4] = inv_sbox(x[4*i +: 4]);
    return y;
  endfunction

  // Inverse bit permutation: bit j lands on 4j mod 63, bit 63 stays put.
  function automatic logic [63:0] inv_p_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int j = 0; j < 63; j++) y[(4*j) % 63] = x[j];
    y[63] = x[63];
    return y;
  endfunction

  // NOTE: combinational logic uses blocking '=' so later statements see earlier results;
  // every variable gets a full assignment first so no latch can be inferred.
  always_comb begin
    logic [79:0] tmp;
    key_fwd_d          = {key_q[18:0], key_q[79:19]};
    key_fwd_d[79:76]   = sbox(key_fwd_d[79:76]);
    key_fwd_d[19:15]   = key_fwd_d[19:15] ^ r_q;

    tmp                = key_q;
    tmp[19:15]         = tmp[19:15] ^ r_q;
    tmp[79:76]         = inv_sbox(tmp[79:76]);
    key_inv_d          = {tmp[60:0], tmp[79:61]};

    state_dec_d        = inv_s_layer(inv_p_layer(state_q ^ key_q[79:16]));
  end

`ifdef PRESENT_DEC_KEY_REUSE_EN
  logic [79:0] cache_key_q;
  logic [79:0] cache_rk_q;
  logic        cache_valid_q;
  logic        cache_hit;

  assign cache_hit = cache_valid_q && (key_in == cache_key_q);
`endif

  // NOTE: all state is updated with non-blocking '<=' so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q         <= IDLE;
      state_q       <= '0;
      key_q         <= '0;
      r_q           <= '0;
      plaintext_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef PRESENT_DEC_KEY_REUSE_EN
      cache_valid_q <= 1'b0;
      cache_key_q   <= '0;
      cache_rk_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (fsm_q)
        IDLE: begin
          if (start) begin
            state_q <= ciphertext;
            busy_q  <= 1'b1;
`ifdef PRESENT_DEC_KEY_REUSE_EN
            if (cache_hit) begin
              key_q <= cache_rk_q;
              r_q   <= ROUNDS_L;
              fsm_q <= DEC;
            end else begin
              key_q         <= key_in;
              r_q           <= 5'd1;
              fsm_q         <= KEYEXP;
              cache_key_q   <= key_in;
              cache_valid_q <= 1'b0;
            end
`else
            key_q <= key_in;
            r_q   <= 5'd1;
            fsm_q <= KEYEXP;
`endif
          end
        end
        KEYEXP: begin
          key_q <= key_fwd_d;
          if (r_q == ROUNDS_L) begin
            r_q   <= ROUNDS_L;
            fsm_q <= DEC;
`ifdef PRESENT_DEC_KEY_REUSE_EN
            cache_rk_q    <= key_fwd_d;
            cache_valid_q <= 1'b1;
`endif
          end else begin
            r_q <= r_q + 5'd1;
          end
        end
        DEC: begin
          state_q <= state_dec_d;
          key_q   <= key_inv_d;
          r_q     <= r_q - 5'd1;
          if (r_q == 5'd1) fsm_q <= FINAL;
        end
        FINAL: begin
          plaintext_q <= state_q ^ key_q[79:16];
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          fsm_q       <= IDLE;
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign plaintext = plaintext_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_present_dec.sv
// Directed bench for present_dec: known-answer vectors, latency, back-to-back, busy/reset behaviour.
// Latency is counted as the edge that first samples done high, start-sampling edge being edge 0.
module tb_present_dec;

  localparam int R        = 31;
  localparam int LAT_FULL = 2*R + 2;
  localparam int LAT_HIT  = R + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] ciphertext;
  logic [79:0] key_in;
  logic [63:0] plaintext;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  localparam logic [79:0] KEY_0 = 80'h0;
  localparam logic [79:0] KEY_F = {80{1'b1}};

  present_dec #(.ROUNDS(R)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ciphertext(ciphertext),
    .key_in    (key_in),
    .plaintext (plaintext),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Called away from an edge; returns #1 after the edge that sampled start.
  task automatic issue_start(input logic [63:0] ct, input logic [79:0] k);
    ciphertext = ct;
    key_in     = k;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // first_edge is the index of the next edge after the start-sampling edge 0.
  task automatic wait_done(input string name, input int first_edge,
                           output logic [63:0] pt, output int lat);
    logic [63:0] pt0;
    bit          changed;
    pt0     = plaintext;
    changed = 1'b0;
    lat     = -1;
    pt      = 'x;
    for (int e = first_edge; e <= first_edge + 200; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = e + 1;
        pt  = plaintext;
        break;
      end
      if (plaintext !== pt0) changed = 1'b1;
    end
    checks++;
    if (lat < 0) begin
      errors++;
      $display("FAIL %s_timeout: no done within 200 edges", name);
    end
    checks++;
    if (changed) begin
      errors++;
      $display("FAIL %s_pt_hold: plaintext changed before done, was %h", name, pt0);
    end
  endtask

  task automatic run_known(input string name, input logic [63:0] ct, input logic [79:0] k,
                           input logic [63:0] exp_pt, input int exp_lat);
    logic [63:0] pt;
    int          lat;
    @(negedge clk);
    issue_start(ct, k);
    wait_done(name, 1, pt, lat);
    checks++;
    if (pt !== exp_pt) begin
      errors++;
      $display("FAIL %s_pt: got %h expected %h", name, pt, exp_pt);
    end
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_width: done=%b expected 0 one cycle later", name, done);
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    start      = 1'b1;
    ciphertext = 64'h0123456789ABCDEF;
    key_in     = KEY_F;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++;
    if (plaintext !== 64'h0) begin
      errors++;
      $display("FAIL reset_pt: got %h expected 0", plaintext);
    end
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_known_vectors();
    run_known("kat_key0", 64'h5579C1387B228445, KEY_0, 64'h0, LAT_FULL);
    run_known("kat_keyF", 64'hE72C46C0F5945049, KEY_F, 64'h0, LAT_FULL);
  endtask

  task automatic test_start_while_busy();
    logic [63:0] pt;
    int          lat;
    int          extra;
    @(negedge clk);
    issue_start(64'h5579C1387B228445, KEY_0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    start      = 1'b1;
    ciphertext = 64'hA112FFC72F68417B;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("busy_start", 11, pt, lat);
    checks++;
    if (pt !== 64'h0) begin
      errors++;
      $display("FAIL busy_start_pt: got %h expected 0000000000000000", pt);
    end
    checks++;
    if (lat != LAT_FULL) begin
      errors++;
      $display("FAIL busy_start_latency: got %0d expected %0d", lat, LAT_FULL);
    end
    extra = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL busy_start_extra_done: got %0d extra done pulses expected 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] pt;
    int          lat;
    @(negedge clk);
    issue_start(64'hA112FFC72F68417B, KEY_0);
    wait_done("b2b_first", 1, pt, lat);
    checks++;
    if (pt !== 64'hFFFFFFFFFFFFFFFF) begin
      errors++;
      $display("FAIL b2b_first_pt: got %h expected FFFFFFFFFFFFFFFF", pt);
    end
    // Still in the done cycle: the next edge must accept this start.
    issue_start(64'h3333DCD3213210D2, KEY_F);
    wait_done("b2b_second", 1, pt, lat);
    checks++;
    if (pt !== 64'hFFFFFFFFFFFFFFFF) begin
      errors++;
      $display("FAIL b2b_second_pt: got %h expected FFFFFFFFFFFFFFFF", pt);
    end
    checks++;
    if (lat != LAT_FULL) begin
      errors++;
      $display("FAIL b2b_second_latency: got %0d expected %0d", lat, LAT_FULL);
    end
  endtask

  task automatic test_abort();
    int seen;
    @(negedge clk);
    issue_start(64'h5579C1387B228445, KEY_0);
    repeat (39) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++;
    if (plaintext !== 64'h0) begin
      errors++;
      $display("FAIL abort_pt: got %h expected 0", plaintext);
    end
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_done: got %0d done pulses expected 0", seen);
    end
    run_known("after_abort", 64'h5579C1387B228445, KEY_0, 64'h0, LAT_FULL);
  endtask

  task automatic test_key_reuse();
`ifdef PRESENT_DEC_KEY_REUSE_EN
    localparam int LAT_REPEAT = LAT_HIT;
`else
    localparam int LAT_REPEAT = LAT_FULL;
`endif
    run_known("reuse_other", 64'hE72C46C0F5945049, KEY_F, 64'h0, LAT_FULL);
    run_known("reuse_first", 64'h5579C1387B228445, KEY_0, 64'h0, LAT_FULL);
    run_known("reuse_repeat", 64'h5579C1387B228445, KEY_0, 64'h0, LAT_REPEAT);
    run_known("reuse_repeat_ff", 64'hA112FFC72F68417B, KEY_0, 64'hFFFFFFFFFFFFFFFF, LAT_REPEAT);
    run_known("reuse_newkey", 64'h3333DCD3213210D2, KEY_F, 64'hFFFFFFFFFFFFFFFF, LAT_FULL);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    ciphertext = '0;
    key_in     = '0;
    test_reset();
    test_known_vectors();
    test_start_while_busy();
    test_back_to_back();
    test_abort();
    test_key_reuse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
